dma_multichannel_ctrl: RTL and testbench

// - Parametrised multi-channel memory-to-memory DMA; successor to the single-channel top-level DMA.
// - Holds NUM_CH independent descriptors (source, destination, length) and arbitrates one shared synchronous memory port round-robin, byte by byte.
// - Signals completion with a per-channel sticky INT, cleared by the host with load.

---
 rtl/dma_multichannel_ctrl_pkg.sv | 22 ++
 rtl/dma_multichannel_ctrl_if.sv | 40 ++++
 rtl/dma_rr_arbiter.sv | 33 +++
 rtl/dma_multichannel_ctrl.sv | 158 +++++++++++++++
 tb/tb_dma_multichannel_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_multichannel_ctrl_pkg.sv
// Shared types and default widths for the multi-channel DMA controller.
// The testbench imports this package as well.
package dma_multichannel_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 5;
    localparam int DEF_NUM_CH = 2;

    // Each word moves through one pass of ARB -> RD -> CAP -> WR.
    typedef enum logic [1:0] {
        ARB = 2'd0,
        RD  = 2'd1,
        CAP = 2'd2,
        WR  = 2'd3
    } dma_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_multichannel_ctrl_if.sv
// Host programming and memory-port signals of the DMA, bundled.
// The slave modport is the DMA's own view of the bundle.
interface dma_multichannel_ctrl_if
    import dma_multichannel_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [CH_W-1:0]   ch_sel;
    logic [ADDR_W-1:0] OriginAddress;
    logic [ADDR_W-1:0] DestinationAddress;
    logic [LEN_W-1:0]  BytesQuantity;
    logic              start;
    logic              load;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Output;
    logic              nW_R;
    logic              CE;
    logic [NUM_CH-1:0] INT;
    logic              ACK;
    logic [NUM_CH-1:0] busy;

    modport slave (
        input  ch_sel, OriginAddress, DestinationAddress, BytesQuantity,
        input  start, load, DataIn,
        output Address, Output, nW_R, CE, INT, ACK, busy
    );

    modport master (
        output ch_sel, OriginAddress, DestinationAddress, BytesQuantity,
        output start, load, DataIn,
        input  Address, Output, nW_R, CE, INT, ACK, busy
    );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index
// strictly after the last-served one, wrapping around.
module dma_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o
);
    localparam int unsigned N = NUM_CH;

    logic            found;
    logic [CH_W-1:0] cand;

    // The last-served channel is tried last (i == N), so it only wins when alone.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = CH_W'((32'(last_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_multichannel_ctrl.sv
// Multi-channel memory-to-memory DMA: per-channel descriptors, one shared
// synchronous memory port, round-robin one word at a time.
module dma_multichannel_ctrl
    import dma_multichannel_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input logic                  clk,
    input logic                  rst,
    dma_multichannel_ctrl_if.slave bus
);
    localparam int CH_W = ch_width(NUM_CH);
    localparam int unsigned NCH = NUM_CH;

    dma_state_e        state_q, state_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0] src_q [NUM_CH];
    logic [ADDR_W-1:0] src_d [NUM_CH];
    logic [ADDR_W-1:0] dst_q [NUM_CH];
    logic [ADDR_W-1:0] dst_d [NUM_CH];
    logic [LEN_W-1:0]  cnt_q [NUM_CH];
    logic [LEN_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] int_q, int_d;
    logic              ack_q, ack_d;
    logic              ce_q, ce_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   sel;
    logic              sel_ok;

    assign sel    = bus.ch_sel;
    assign sel_ok = ({1'b0, sel} < (CH_W+1)'(NUM_CH));

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i  (busy_q),
        .last_i (cur_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // Output registers are loaded on entry to a state, so the state name
    // describes what the memory port shows during that cycle.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        int_d   = int_q;
        ack_d   = 1'b0;
        ce_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;

        case (state_q)
            ARB: begin
                if (|gnt) begin
                    cur_d   = gnt_idx;
                    state_d = RD;
                    ce_d    = 1'b1;
                    addr_d  = src_q[gnt_idx];
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                state_d = WR;
                ce_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_q[cur_q];
                dout_d  = bus.DataIn;
            end
            WR: begin
                state_d       = ARB;
                src_d[cur_q]  = src_q[cur_q] + ADDR_W'(1);
                dst_d[cur_q]  = dst_q[cur_q] + ADDR_W'(1);
                cnt_d[cur_q]  = cnt_q[cur_q] - LEN_W'(1);
                if (cnt_q[cur_q] == LEN_W'(1)) begin
                    busy_d[cur_q] = 1'b0;
                    int_d[cur_q]  = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        // Host side runs after the engine; an accepted start overrides load.
        if (bus.load && sel_ok) begin
            int_d[sel] = 1'b0;
        end
        if (bus.start && sel_ok && !busy_q[sel]) begin
            src_d[sel] = bus.OriginAddress;
            dst_d[sel] = bus.DestinationAddress;
            cnt_d[sel] = bus.BytesQuantity;
            ack_d      = 1'b1;
            if (bus.BytesQuantity == '0) begin
                int_d[sel] = 1'b1;
            end else begin
                int_d[sel]  = 1'b0;
                busy_d[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            cur_q   <= CH_W'(NUM_CH - 1);
            for (int unsigned i = 0; i < NCH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            busy_q  <= '0;
            int_q   <= '0;
            ack_q   <= 1'b0;
            ce_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            int_q   <= int_d;
            ack_q   <= ack_d;
            ce_q    <= ce_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.Address = addr_q;
    assign bus.Output  = dout_q;
    assign bus.nW_R    = wr_q;
    assign bus.CE      = ce_q;
    assign bus.INT     = int_q;
    assign bus.ACK     = ack_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dma_multichannel_ctrl.sv
// Directed bench for dma_multichannel_ctrl: synchronous memory model,
// access log sampled just after each rising edge, hand-computed expectations.
module tb_dma_multichannel_ctrl;
    import dma_multichannel_ctrl_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 5;
    localparam int NUM_CH = 2;
    localparam int CH_W   = ch_width(NUM_CH);

    localparam int EXP2_WA [5] = '{100, 300, 101, 301, 102};
    localparam int EXP2_WD [5] = '{'hAA, 'h11, 'hAA, 'h22, 'hAA};
    localparam int EXP3_RA [4] = '{1022, 1023, 0, 1};
    localparam int EXP3_WD [4] = '{'hC2, 'hC3, 'hAA, 'hAA};
    localparam int EXP5_WD [3] = '{'h14, 'h15, 'h16};

    typedef struct {
        int addr;
        bit wr;
        int data;
    } acc_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    acc_t log_q[$];
    logic [DATA_W-1:0] mem [1024];

    dma_multichannel_ctrl_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .NUM_CH (NUM_CH)
    ) bus ();

    dma_multichannel_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Read data is valid only in the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.CE && !bus.nW_R) bus.DataIn <= mem[bus.Address];
        else                     bus.DataIn <= '0;
    end

    always begin
        @(posedge clk);
        #1;
        if (bus.CE) log_q.push_back('{int'(bus.Address), bus.nW_R, int'(bus.Output)});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_ch(input int ch, input int src, input int dst, input int len);
        @(negedge clk);
        bus.ch_sel             = CH_W'(ch);
        bus.OriginAddress      = ADDR_W'(src);
        bus.DestinationAddress = ADDR_W'(dst);
        bus.BytesQuantity      = LEN_W'(len);
        bus.start              = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic load_ch(input int ch);
        @(negedge clk);
        bus.ch_sel = CH_W'(ch);
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_int(input int ch, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.INT[ch]) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("int_wait", int'(t >= 0), 1);
    endtask

    function automatic int count_wr(input int from);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) if (log_q[i].wr) n++;
        return n;
    endfunction

    initial begin
        int base, t0, t1, ti0, ti1, k;

        rst = 1'b0;
        bus.start = 1'b0;
        bus.load = 1'b0;
        bus.ch_sel = '0;
        bus.OriginAddress = '0;
        bus.DestinationAddress = '0;
        bus.BytesQuantity = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i) ^ 8'h3C;
        for (int i = 0; i < 10; i++) mem[i] = 8'hAA;
        mem[200] = 8'h11;
        mem[201] = 8'h22;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ce",   int'(bus.CE), 0);
        check_eq("rst_nwr",  int'(bus.nW_R), 0);
        check_eq("rst_addr", int'(bus.Address), 0);
        check_eq("rst_out",  int'(bus.Output), 0);
        check_eq("rst_ack",  int'(bus.ACK), 0);
        check_eq("rst_int",  int'(bus.INT), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        rst = 1'b1;
        base = log_q.size();
        repeat (5) @(negedge clk);
        check_eq("idle_ce", log_q.size() - base, 0);

        // Single 10-word transfer on ch0
        base = log_q.size();
        start_ch(0, 0, 20, 10);
        t0 = cyc;
        check_eq("t1_ack",  int'(bus.ACK), 1);
        check_eq("t1_busy", int'(bus.busy[0]), 1);
        @(negedge clk);
        check_eq("t1_ack_pulse", int'(bus.ACK), 0);
        wait_int(0, 80, t1);
        check_eq("t1_latency", t1 - t0, 40);
        check_eq("t1_busy_done", int'(bus.busy[0]), 0);
        check_eq("t1_nacc", log_q.size() - base, 20);
        for (int i = 0; i < 10; i++) begin
            check_eq("t1_rd_addr", log_q[base + 2*i].addr, i);
            check_eq("t1_wr_addr", log_q[base + 2*i + 1].addr, 20 + i);
            check_eq("t1_wr_data", log_q[base + 2*i + 1].data, 'hAA);
        end
        load_ch(0);
        check_eq("t1_load_clr", int'(bus.INT[0]), 0);

        // Two channels started on consecutive cycles
        base = log_q.size();
        @(negedge clk);
        bus.ch_sel = 1'b0; bus.OriginAddress = 10'd0;
        bus.DestinationAddress = 10'd100; bus.BytesQuantity = 5'd3; bus.start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        check_eq("t2_ack0", int'(bus.ACK), 1);
        bus.ch_sel = 1'b1; bus.OriginAddress = 10'd200;
        bus.DestinationAddress = 10'd300; bus.BytesQuantity = 5'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("t2_ack1", int'(bus.ACK), 1);
        ti0 = -1;
        ti1 = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.INT[1] && ti1 < 0) ti1 = cyc;
            if (bus.INT[0] && ti0 < 0) ti0 = cyc;
            if (ti0 >= 0 && ti1 >= 0) break;
            @(negedge clk);
        end
        check_eq("t2_int1_time", ti1 - t0, 16);
        check_eq("t2_int0_time", ti0 - t0, 20);
        k = 0;
        for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i].wr) begin
                if (k < 5) begin
                    check_eq("t2_wr_addr", log_q[i].addr, EXP2_WA[k]);
                    check_eq("t2_wr_data", log_q[i].data, EXP2_WD[k]);
                end
                k++;
            end
        end
        check_eq("t2_nwr", k, 5);

        // Source address wrap on ch1
        base = log_q.size();
        start_ch(1, 1022, 500, 4);
        check_eq("t3_ack", int'(bus.ACK), 1);
        check_eq("t3_int_clr", int'(bus.INT[1]), 0);
        wait_int(1, 40, t1);
        check_eq("t3_nacc", log_q.size() - base, 8);
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_rd_addr", log_q[base + 2*i].addr, EXP3_RA[i]);
            check_eq("t3_wr_addr", log_q[base + 2*i + 1].addr, 500 + i);
            check_eq("t3_wr_data", log_q[base + 2*i + 1].data, EXP3_WD[i]);
        end

        // Zero-length descriptor
        load_ch(0);
        check_eq("t4_pre_clr", int'(bus.INT[0]), 0);
        base = log_q.size();
        start_ch(0, 5, 5, 0);
        check_eq("t4_ack",  int'(bus.ACK), 1);
        check_eq("t4_int",  int'(bus.INT[0]), 1);
        check_eq("t4_busy", int'(bus.busy[0]), 0);
        repeat (6) @(negedge clk);
        check_eq("t4_no_ce", log_q.size() - base, 0);

        // Start to a busy channel is ignored
        base = log_q.size();
        start_ch(0, 40, 600, 3);
        t0 = cyc;
        check_eq("t5_ack", int'(bus.ACK), 1);
        check_eq("t5_int_clr", int'(bus.INT[0]), 0);
        start_ch(0, 50, 700, 1);
        check_eq("t5_busy_noack", int'(bus.ACK), 0);
        wait_int(0, 40, t1);
        check_eq("t5_latency", t1 - t0, 12);
        check_eq("t5_nwr", count_wr(base), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t5_wr_addr", log_q[base + 2*i + 1].addr, 600 + i);
            check_eq("t5_wr_data", log_q[base + 2*i + 1].data, EXP5_WD[i]);
        end

        // Reset in the middle of a transfer
        base = log_q.size();
        start_ch(1, 60, 800, 5);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (log_q.size() - base >= 5) begin
                k = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t6_reached", k, 1);
        check_eq("t6_ce_before", int'(bus.CE), 1);
        rst = 1'b0;
        #1;
        check_eq("t6_ce",   int'(bus.CE), 0);
        check_eq("t6_addr", int'(bus.Address), 0);
        check_eq("t6_out",  int'(bus.Output), 0);
        check_eq("t6_nwr",  int'(bus.nW_R), 0);
        check_eq("t6_busy", int'(bus.busy), 0);
        check_eq("t6_int",  int'(bus.INT), 0);
        check_eq("t6_ack",  int'(bus.ACK), 0);
        @(negedge clk);
        rst = 1'b1;
        base = log_q.size();
        repeat (10) @(negedge clk);
        check_eq("t6_quiet", log_q.size() - base, 0);
        check_eq("t6_int_after", int'(bus.INT), 0);
        check_eq("t6_busy_after", int'(bus.busy), 0);

        // Same-cycle load and start on ch0 with INT pending
        start_ch(0, 0, 0, 0);
        check_eq("t7_int_pend", int'(bus.INT[0]), 1);
        base = log_q.size();
        @(negedge clk);
        bus.ch_sel = 1'b0; bus.OriginAddress = 10'd70;
        bus.DestinationAddress = 10'd900; bus.BytesQuantity = 5'd3;
        bus.start = 1'b1; bus.load = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.load = 1'b0;
        t0 = cyc;
        check_eq("t7_int_clr", int'(bus.INT[0]), 0);
        check_eq("t7_ack",     int'(bus.ACK), 1);
        check_eq("t7_busy",    int'(bus.busy[0]), 1);
        wait_int(0, 40, t1);
        check_eq("t7_latency", t1 - t0, 12);
        check_eq("t7_nwr", count_wr(base), 3);
        check_eq("t7_last_wr", log_q[log_q.size() - 1].addr, 902);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
